// File: rtl/axis_sched_pkg.sv
// Shared types, constants and the round-robin destination search used by
// the AXI-stream fan-out scheduler.
package axis_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_e;

    localparam int CNT_W      = 16;
    localparam int MAX_FANOUT = 32;
    localparam int DEST_IDX_W = 5;

    // Next set mask bit strictly after cur, wrapping; returns cur if it is the
    // only set bit (or if the mask is empty, which callers handle separately).
    // Unused upper mask bits are zero, so wrapping over MAX_FANOUT positions
    // gives the same answer as wrapping over the real destination count.
    function automatic logic [DEST_IDX_W-1:0] next_dest(
        input logic [MAX_FANOUT-1:0] mask,
        input logic [DEST_IDX_W-1:0] cur
    );
        logic [DEST_IDX_W-1:0] res;
        logic [DEST_IDX_W-1:0] idx;
        logic                  found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= MAX_FANOUT; k++) begin
            idx = cur + DEST_IDX_W'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [DEST_IDX_W-1:0] lowest_dest(
        input logic [MAX_FANOUT-1:0] mask
    );
        return next_dest(mask, '1);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid stage: output register plus one overflow slot.
// Input ready depends only on the overflow slot, never on out_ready.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             push;

    assign in_ready  = !skid_valid_q;
    assign push      = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_data_d = in_data;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_fan_out_sched.sv
// Round-robin tdest scheduler for axis_fan_out: tags each accepted beat with
// the current destination and rotates over the enable mask at burst boundaries.
module axis_fan_out_sched
    import axis_sched_pkg::*;
#(
    parameter int NUM_FANOUT      = 6,
    parameter int DATA_WIDTH      = 256,
    parameter int SWITCH_ON_TLAST = 1,
    parameter int BEATS_PER_DEST  = 64
) (
    input  logic                  s_axis_clk,
    input  logic                  s_axis_rstn,
    input  logic [NUM_FANOUT-1:0] cfg_dest_mask,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_FANOUT-1:0] m_axis_tdest,
    output logic                  m_axis_tlast,
    output logic [NUM_FANOUT-1:0] stat_dest,
    output logic                  stat_busy
);

    localparam int PKT_W = DATA_WIDTH + NUM_FANOUT + 1;

    sched_state_e          state_q, state_d;
    logic [DEST_IDX_W-1:0] cur_dest_q, cur_dest_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

    logic [MAX_FANOUT-1:0] mask_ext;
    logic [NUM_FANOUT-1:0] dest_ext;
    logic                  skid_in_ready;
    logic                  accept;
    logic                  boundary;
    logic [PKT_W-1:0]      skid_in_data;
    logic [PKT_W-1:0]      skid_out_data;

    assign mask_ext      = MAX_FANOUT'(cfg_dest_mask);
    assign dest_ext      = NUM_FANOUT'(cur_dest_q);
    assign s_axis_tready = (state_q == ST_STREAM) && skid_in_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign boundary      = accept && ((SWITCH_ON_TLAST != 0) ? s_axis_tlast
                                      : (beat_cnt_q == CNT_W'(BEATS_PER_DEST - 1)));
    assign stat_dest     = dest_ext;
    assign stat_busy     = (state_q == ST_STREAM);

    always_comb begin
        state_d    = state_q;
        cur_dest_d = cur_dest_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mask_ext != '0) begin
                    cur_dest_d = lowest_dest(mask_ext);
                    beat_cnt_d = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (boundary) begin
                        // Mask is only looked at here, so mid-burst edits wait.
                        beat_cnt_d = '0;
                        if (mask_ext == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cur_dest_d = next_dest(mask_ext, cur_dest_q);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
        if (!s_axis_rstn) begin
            state_q    <= ST_IDLE;
            cur_dest_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_dest_q <= cur_dest_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign skid_in_data = {s_axis_tdata, dest_ext, s_axis_tlast};

    axis_skid_buffer #(
        .WIDTH(PKT_W)
    ) u_skid (
        .clk      (s_axis_clk),
        .rst_n    (s_axis_rstn),
        .in_valid (s_axis_tvalid && (state_q == ST_STREAM)),
        .in_ready (skid_in_ready),
        .in_data  (skid_in_data),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready),
        .out_data (skid_out_data)
    );

    assign {m_axis_tdata, m_axis_tdest, m_axis_tlast} = skid_out_data;

endmodule
